cva6_hpdcache_req_arbiter: RTL and testbench

//  Shares one HPDcache request/response port among NREQ CVA6-side requesters
//  (load, store/AMO, PTW, accelerator). Each requester presents an already-adapted

---
 rtl/cva6_hpdcache_arb_pkg.sv | 38 +++
 rtl/cva6_hpdcache_rr_arbiter.sv | 42 ++++
 rtl/cva6_hpdcache_req_arbiter.sv | 143 ++++++++++++++
 tb/tb_cva6_hpdcache_req_arbiter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cva6_hpdcache_arb_pkg.sv
// Shared types for the HPDcache requester arbiter: index/counter widths and
// the request, response, tag and PMA payloads it routes.
package cva6_hpdcache_arb_pkg;

    localparam int ARB_MAX_NREQ = 8;
    localparam int ARB_IDX_W    = 3;
    localparam int ARB_CNT_W    = 4;

    typedef logic [ARB_IDX_W-1:0] arb_idx_t;
    typedef logic [ARB_CNT_W-1:0] arb_cnt_t;

    typedef logic [19:0] hpdcache_tag_t;

    typedef struct packed {
        logic uncacheable;
        logic io;
    } hpdcache_pma_t;

    typedef struct packed {
        logic [11:0] addr_offset;
        logic [3:0]  op;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [2:0]  size;
        arb_idx_t    sid;
        logic [3:0]  tid;
        logic        need_rsp;
        logic        phys_indexed;
    } hpdcache_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        arb_idx_t    sid;
        logic [3:0]  tid;
        logic        error;
    } hpdcache_rsp_t;

endpackage

// File: rtl/cva6_hpdcache_rr_arbiter.sv
// Pure round-robin grant: the requester nearest after the pointer (cyclically) wins.
module cva6_hpdcache_rr_arbiter
    import cva6_hpdcache_arb_pkg::*;
#(
    parameter int NREQ = 3
) (
    input  logic [NREQ-1:0] req,
    input  arb_idx_t        ptr,
    output logic [NREQ-1:0] gnt,
    output arb_idx_t        gnt_idx,
    output logic            any
);

    int   dist_s;
    int   best_s;
    logic hit_s;

    // Distance 0 is the slot right after ptr; smallest distance wins
    always_comb begin
        dist_s  = 0;
        best_s  = NREQ;
        hit_s   = 1'b0;
        gnt_idx = {ARB_IDX_W{1'b0}};
        any     = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            dist_s  = (i + NREQ - 1 - int'(ptr)) % NREQ;
            hit_s   = req[i] && (dist_s < best_s);
            best_s  = hit_s ? dist_s : best_s;
            gnt_idx = hit_s ? arb_idx_t'(i) : gnt_idx;
            any     = any | hit_s;
        end
    end

    // One-hot view of the winning index
    always_comb begin
        gnt = {NREQ{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            gnt[i] = any && (gnt_idx == arb_idx_t'(i));
        end
    end

endmodule

// File: rtl/cva6_hpdcache_req_arbiter.sv
// Shares one HPDcache request port among NREQ requesters: round-robin with lock,
// per-requester outstanding-response credits, late abort/tag/PMA forwarding, response demux.
module cva6_hpdcache_req_arbiter
    import cva6_hpdcache_arb_pkg::*;
#(
    parameter int NREQ            = 3,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [NREQ-1:0] req_valid_i,
    output logic [NREQ-1:0] req_ready_o,
    input  hpdcache_req_t   req_i [NREQ],
    input  logic [NREQ-1:0] req_abort_i,
    input  hpdcache_tag_t   req_tag_i [NREQ],
    input  hpdcache_pma_t   req_pma_i [NREQ],
    output logic            hpdcache_req_valid_o,
    input  logic            hpdcache_req_ready_i,
    output hpdcache_req_t   hpdcache_req_o,
    output logic            hpdcache_req_abort_o,
    output hpdcache_tag_t   hpdcache_req_tag_o,
    output hpdcache_pma_t   hpdcache_req_pma_o,
    input  logic            hpdcache_rsp_valid_i,
    input  hpdcache_rsp_t   hpdcache_rsp_i,
    output logic [NREQ-1:0] rsp_valid_o,
    output hpdcache_rsp_t   rsp_o,
    output logic            rsp_error_o
);

    localparam arb_cnt_t CNT_MAX = arb_cnt_t'(MAX_OUTSTANDING);
    localparam arb_idx_t PTR_RST = arb_idx_t'(NREQ - 1);

    logic [NREQ-1:0] eligible_s, rr_gnt_s, grant_oh_s, inc_s, dec_s;
    arb_idx_t        rr_idx_s, grant_idx_s, ptr_r, lock_idx_r, s1_idx_r;
    logic            rr_any_s, valid_s, handshake_s;
    logic            lock_valid_r, s1_valid_r;
    arb_cnt_t        cnt_r [NREQ];
    hpdcache_req_t   grant_req_s;

    // A need_rsp request only competes while its requester has a free credit
    always_comb begin
        eligible_s = {NREQ{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            eligible_s[i] = req_valid_i[i] && (!req_i[i].need_rsp || (cnt_r[i] < CNT_MAX));
        end
    end

    cva6_hpdcache_rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr (
        .req     (eligible_s),
        .ptr     (ptr_r),
        .gnt     (rr_gnt_s),
        .gnt_idx (rr_idx_s),
        .any     (rr_any_s)
    );

    // A stalled grant stays with its owner until the cache accepts it
    always_comb begin
        grant_idx_s = lock_valid_r ? lock_idx_r : rr_idx_s;
        valid_s     = lock_valid_r | rr_any_s;
        handshake_s = valid_s & hpdcache_req_ready_i;
        grant_oh_s  = {NREQ{1'b0}};
        grant_req_s = req_i[0];
        for (int i = 0; i < NREQ; i++) begin
            grant_oh_s[i] = lock_valid_r ? (lock_idx_r == arb_idx_t'(i)) : rr_gnt_s[i];
            grant_req_s   = (grant_idx_s == arb_idx_t'(i)) ? req_i[i] : grant_req_s;
        end
    end

    // Request path to the cache, sid rewritten to the owner index
    always_comb begin
        hpdcache_req_valid_o = valid_s & ~rst_i;
        req_ready_o          = grant_oh_s & {NREQ{valid_s & hpdcache_req_ready_i & ~rst_i}};
        hpdcache_req_o       = grant_req_s;
        hpdcache_req_o.sid   = grant_idx_s;
    end

    // Late abort/tag/PMA come from the requester that handshook last cycle
    always_comb begin
        hpdcache_req_abort_o = 1'b0;
        hpdcache_req_tag_o   = hpdcache_tag_t'(20'd0);
        hpdcache_req_pma_o   = hpdcache_pma_t'(2'b00);
        for (int i = 0; i < NREQ; i++) begin
            if (s1_valid_r && (s1_idx_r == arb_idx_t'(i))) begin
                hpdcache_req_abort_o = req_abort_i[i];
                hpdcache_req_tag_o   = req_tag_i[i];
                hpdcache_req_pma_o   = req_pma_i[i];
            end else begin
                hpdcache_req_abort_o = hpdcache_req_abort_o;
            end
        end
    end

    // A response is only legal for a requester with a credit in use (or gaining one now)
    always_comb begin
        inc_s = {NREQ{1'b0}};
        dec_s = {NREQ{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            inc_s[i] = handshake_s && grant_oh_s[i] && grant_req_s.need_rsp;
            dec_s[i] = hpdcache_rsp_valid_i && (hpdcache_rsp_i.sid == arb_idx_t'(i)) &&
                       ((cnt_r[i] != arb_cnt_t'(0)) || inc_s[i]);
        end
        rsp_valid_o = dec_s & {NREQ{~rst_i}};
        rsp_error_o = hpdcache_rsp_valid_i & ~(|dec_s) & ~rst_i;
        rsp_o       = hpdcache_rsp_i;
    end

    // Lock, round-robin pointer and stage-1 owner
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_r        <= PTR_RST;
            lock_valid_r <= 1'b0;
            lock_idx_r   <= arb_idx_t'(0);
            s1_valid_r   <= 1'b0;
            s1_idx_r     <= arb_idx_t'(0);
        end else begin
            lock_valid_r <= valid_s & ~hpdcache_req_ready_i;
            lock_idx_r   <= grant_idx_s;
            s1_valid_r   <= handshake_s & ~grant_req_s.phys_indexed;
            s1_idx_r     <= grant_idx_s;
            ptr_r        <= handshake_s ? grant_idx_s : ptr_r;
        end
    end

    // Outstanding-response counters
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREQ; i++) begin
                cnt_r[i] <= arb_cnt_t'(0);
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                case ({inc_s[i], dec_s[i]})
                    2'b10:   cnt_r[i] <= cnt_r[i] + arb_cnt_t'(1);
                    2'b01:   cnt_r[i] <= cnt_r[i] - arb_cnt_t'(1);
                    default: cnt_r[i] <= cnt_r[i];
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cva6_hpdcache_req_arbiter.sv
// Self-checking bench: directed scenarios then random traffic, checked every cycle
// against a credit/round-robin reference model kept in plain integers.
module tb_cva6_hpdcache_req_arbiter;
    import cva6_hpdcache_arb_pkg::*;

    localparam int N    = 3;
    localparam int MAXO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req_valid, req_ready, req_abort, rsp_valid;
    hpdcache_req_t req [N];
    hpdcache_tag_t tag [N];
    hpdcache_pma_t pma [N];
    logic          c_valid, c_ready, c_abort, c_rsp_valid, rsp_error;
    hpdcache_req_t c_req;
    hpdcache_tag_t c_tag;
    hpdcache_pma_t c_pma;
    hpdcache_rsp_t c_rsp, rsp;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    int m_cnt [N];
    int m_ptr, m_lock, m_s1;

    // observed snapshots of the most recent step
    int           last_g;
    logic         last_valid, last_abort, last_err;
    logic [N-1:0] last_ready, last_rv;
    logic [19:0]  last_tag;

    always #5 clk = ~clk;

    cva6_hpdcache_req_arbiter #(.NREQ(N), .MAX_OUTSTANDING(MAXO)) dut (
        .clk_i                (clk),
        .rst_i                (rst),
        .req_valid_i          (req_valid),
        .req_ready_o          (req_ready),
        .req_i                (req),
        .req_abort_i          (req_abort),
        .req_tag_i            (tag),
        .req_pma_i            (pma),
        .hpdcache_req_valid_o (c_valid),
        .hpdcache_req_ready_i (c_ready),
        .hpdcache_req_o       (c_req),
        .hpdcache_req_abort_o (c_abort),
        .hpdcache_req_tag_o   (c_tag),
        .hpdcache_req_pma_o   (c_pma),
        .hpdcache_rsp_valid_i (c_rsp_valid),
        .hpdcache_rsp_i       (c_rsp),
        .rsp_valid_o          (rsp_valid),
        .rsp_o                (rsp),
        .rsp_error_o          (rsp_error)
    );

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        m_ptr  = N - 1;
        m_lock = -1;
        m_s1   = -1;
    endtask

    function automatic bit elig(int i);
        return req_valid[i] && (!req[i].need_rsp || m_cnt[i] < MAXO);
    endfunction

    function automatic int pred_grant();
        int g = -1;
        if (m_lock >= 0) return m_lock;
        for (int k = 1; k <= N; k++) begin
            if (g < 0 && elig((m_ptr + k) % N)) g = (m_ptr + k) % N;
        end
        return g;
    endfunction

    task automatic set_req(input int i, input bit v, input bit nr, input bit pi);
        req_valid[i]         = v;
        req[i].addr_offset   = 12'($urandom);
        req[i].op            = 4'($urandom);
        req[i].wdata         = $urandom;
        req[i].be            = 4'($urandom);
        req[i].size          = 3'($urandom);
        req[i].sid           = 3'($urandom);
        req[i].tid           = 4'($urandom);
        req[i].need_rsp      = nr;
        req[i].phys_indexed  = pi;
    endtask

    task automatic idle();
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 1'b0, 1'b1);
        req_abort   = 3'b000;
        c_rsp_valid = 1'b0;
        c_rsp       = '0;
    endtask

    task automatic set_rsp(input bit v, input int sid);
        c_rsp_valid = v;
        c_rsp.rdata = $urandom;
        c_rsp.sid   = 3'(sid);
        c_rsp.tid   = 4'($urandom);
        c_rsp.error = 1'b0;
    endtask

    // Inputs are already driven; check combinational outputs, then advance one clock
    task automatic step();
        int           g, s;
        bit           hs, dlv;
        logic [N-1:0] e_rdy, e_rv;
        logic         e_ab;
        logic [19:0]  e_tag;
        logic [1:0]   e_pma;
        #2;
        g   = pred_grant();
        hs  = (g >= 0) && c_ready;
        s   = int'(c_rsp.sid);
        dlv = c_rsp_valid && (s < N) && ((m_cnt[s] > 0) || (hs && g == s && req[g].need_rsp));
        for (int i = 0; i < N; i++) begin
            e_rdy[i] = hs && (g == i);
            e_rv[i]  = dlv && (s == i);
        end
        e_ab = 1'b0; e_tag = 20'd0; e_pma = 2'b00;
        if (m_s1 >= 0) begin
            e_ab = req_abort[m_s1]; e_tag = tag[m_s1]; e_pma = pma[m_s1];
        end
        chk("req_valid", c_valid, (g >= 0));
        chk("req_ready", req_ready, e_rdy);
        if (g >= 0) begin
            chk("sid", c_req.sid, g);
            chk("addr", c_req.addr_offset, req[g].addr_offset);
        end
        chk("abort", c_abort, e_ab);
        chk("tag", c_tag, e_tag);
        chk("pma", c_pma, e_pma);
        chk("rsp_valid", rsp_valid, e_rv);
        chk("rsp_error", rsp_error, c_rsp_valid && !dlv);
        chk("rsp_data", rsp.rdata, c_rsp.rdata);
        last_g = g; last_valid = c_valid; last_ready = req_ready; last_abort = c_abort;
        last_tag = c_tag; last_rv = rsp_valid; last_err = rsp_error;
        @(posedge clk);
        m_lock = (g >= 0 && !c_ready) ? g : -1;
        m_s1   = (hs && !req[g].phys_indexed) ? g : -1;
        if (hs) begin
            m_ptr = g;
            if (req[g].need_rsp) m_cnt[g]++;
        end
        if (dlv) m_cnt[s]--;
        #1;
    endtask

    initial begin
        int seq [6] = '{0, 1, 2, 0, 1, 2};
        model_reset();
        rst = 1'b1;
        c_ready = 1'b1;
        idle();
        for (int i = 0; i < N; i++) begin
            tag[i] = 20'd0;
            pma[i] = 2'b00;
        end
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, 1'b0);
        #3;
        chk("rst_req_valid", c_valid, 1'b0);
        chk("rst_req_ready", req_ready, 3'b000);
        chk("rst_abort", c_abort, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 3'b000);
        @(posedge clk); #1;
        rst = 1'b0;

        // 1: all valid, ready high -> 0,1,2,0,1,2
        for (int c = 0; c < 6; c++) begin
            step();
            chk("t1_grant", last_g, seq[c]);
        end

        // 2: lock on requester 0 while requester 1 joins
        idle();
        set_req(0, 1'b1, 1'b0, 1'b1);
        c_ready = 1'b0;
        step(); chk("t2_grant0", last_g, 0);
        req_valid[1] = 1'b1;
        step(); chk("t2_grant1", last_g, 0);
        step(); chk("t2_grant2", last_g, 0);
        c_ready = 1'b1;
        step(); chk("t2_hs", last_ready, 3'b001);
        req_valid[0] = 1'b0;
        step(); chk("t2_next", last_g, 1);

        // 3: credit exhaustion on requester 1
        idle();
        for (int c = 0; c < 4; c++) begin
            set_req(1, 1'b1, 1'b1, 1'b1);
            step(); chk("t3_accept", last_ready, 3'b010);
        end
        set_req(1, 1'b1, 1'b1, 1'b1);
        set_rsp(1'b1, 1);
        step();
        chk("t3_blocked", last_ready, 3'b000);
        chk("t3_blocked_valid", last_valid, 1'b0);
        chk("t3_rsp", last_rv, 3'b010);
        set_rsp(1'b0, 0);
        step(); chk("t3_unblock", last_ready, 3'b010);
        req_valid[1] = 1'b0;
        for (int c = 0; c < 4; c++) begin
            set_rsp(1'b1, 1);
            step(); chk("t3_drain", last_rv, 3'b010);
        end

        // 4: late abort/tag forwarding for virtually indexed requests only
        idle();
        set_req(2, 1'b1, 1'b0, 1'b0);
        step();
        req_valid[2] = 1'b0; req_abort[2] = 1'b1; tag[2] = 20'hABCDE;
        step();
        chk("t4_abort", last_abort, 1'b1);
        chk("t4_tag", last_tag, 20'hABCDE);
        set_req(2, 1'b1, 1'b0, 1'b1); req_abort[2] = 1'b0;
        step();
        req_valid[2] = 1'b0; req_abort[2] = 1'b1;
        step();
        chk("t4_phys_abort", last_abort, 1'b0);

        // 5: bad sid and unexpected response
        idle();
        set_rsp(1'b1, 5);
        step(); chk("t5_bad_err", last_err, 1'b1); chk("t5_bad_rv", last_rv, 3'b000);
        set_rsp(1'b1, 0);
        step(); chk("t5_unexp_err", last_err, 1'b1); chk("t5_unexp_rv", last_rv, 3'b000);

        // 6: reset during a lock with three credits used
        idle();
        for (int c = 0; c < 3; c++) begin
            set_req(1, 1'b1, 1'b1, 1'b1);
            step();
        end
        idle();
        set_req(0, 1'b1, 1'b0, 1'b1);
        c_ready = 1'b0;
        step();
        set_rsp(1'b1, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_valid", c_valid, 1'b0);
        chk("t6_ready", req_ready, 3'b000);
        chk("t6_rsp_valid", rsp_valid, 3'b000);
        chk("t6_rsp_err", rsp_error, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        idle();
        c_ready = 1'b1;
        set_rsp(1'b1, 1);
        step(); chk("t6_stale_rsp", last_err, 1'b1);
        idle();
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, 1'b0);
        step(); chk("t6_first_grant", last_g, 0);

        // random traffic
        for (int c = 0; c < 400; c++) begin
            int  g, s;
            bit  v;
            for (int i = 0; i < N; i++) begin
                if (i != m_lock)
                    set_req(i, ($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom));
                req_abort[i] = 1'($urandom);
                tag[i]       = 20'($urandom);
                pma[i]       = 2'($urandom);
            end
            c_ready = ($urandom_range(0, 3) != 0);
            v = 1'($urandom);
            s = $urandom_range(0, 3);
            if (s == 3) s = $urandom_range(3, 7);
            g = pred_grant();
            if (s < N && m_cnt[s] == 0 && g == s && c_ready && req[s].need_rsp) v = 1'b0;
            set_rsp(v, s);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
